// File: rtl/regbank_controller_pkg.sv
// Shared types and defaults for the register bank controller.
// Also provides the default geometry used by the register bank itself.
package regbank_controller_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_IDLE  = 3'd1,
        ST_WRITE = 3'd2,
        ST_READ  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

endpackage

// File: rtl/regbank_sweep_counter.sv
// Address counter for the post-reset clear sweep.
// Saturates at the last entry so the sweep never makes a second pass.
module regbank_sweep_counter
    import regbank_controller_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    output logic [ADDR_W-1:0] count,
    output logic              tc
);

    localparam int DEPTH = 2 ** ADDR_W;

    assign tc = (count == ADDR_W'(DEPTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (en && !tc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/regbank_controller.sv
// Sole initiator of the register bank: clears it after reset, then
// serialises pipeline read/write requests into single-cycle accesses.
module regbank_controller
    import regbank_controller_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0] rb_data_in,
    output logic              rb_write,
    input  logic [DATA_W-1:0] rb_data_out
);

    localparam state_t RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

    state_t            state;
    logic              sweep_last;
    logic              rd_phase;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [ADDR_W-1:0] sweep_cnt;
    logic              sweep_tc;
    logic              sweep_en;

    assign sweep_en = (state == ST_CLEAR) && !sweep_last;

    regbank_sweep_counter #(
        .ADDR_W (ADDR_W)
    ) u_sweep (
        .clk   (clk),
        .reset (reset),
        .en    (sweep_en),
        .count (sweep_cnt),
        .tc    (sweep_tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= RST_STATE;
            sweep_last <= 1'b0;
            rd_phase   <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            rb_write   <= 1'b0;
            rb_addr    <= '0;
            rb_data_in <= '0;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            busy       <= CLEAR_ON_RESET;
        end else begin
            unique case (state)
                ST_CLEAR: begin
                    // Outputs lag one edge, so leave only after the
                    // last entry has been presented for a full cycle.
                    if (sweep_last) begin
                        rb_write  <= 1'b0;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        rb_write   <= 1'b1;
                        rb_addr    <= sweep_cnt;
                        rb_data_in <= '0;
                        sweep_last <= sweep_tc;
                    end
                end
                ST_IDLE: begin
                    rb_write <= 1'b0;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        state     <= req_write ? ST_WRITE : ST_READ;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    rb_write   <= 1'b1;
                    rb_addr    <= lat_addr;
                    rb_data_in <= lat_wdata;
                    req_ready  <= 1'b1;
                    state      <= ST_IDLE;
                end
                ST_READ: begin
                    rb_write <= 1'b0;
                    if (!rd_phase) begin
                        rb_addr  <= lat_addr;
                        rd_phase <= 1'b1;
                    end else begin
                        rd_phase  <= 1'b0;
                        rsp_rdata <= rb_data_out;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= RST_STATE;
                end
            endcase
        end
    end

endmodule
